// File: rtl/cache_miss_controller.sv
// Miss sequencer between the CPU port, a direct-mapped write-back cache and memory.
// Handles dirty write-back, 4-beat refill through a line buffer and the post-fill retry.
module cache_miss_controller #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 5,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              c_en,
    output logic              c_comp,
    output logic              c_write,
    output logic              c_valid_in,
    output logic [ADDR_W-1:0] c_addr,
    output logic [TAG_W-1:0]  c_tag_in,
    output logic [DATA_W-1:0] c_din,
    input  logic              c_hit,
    input  logic              c_dirty,
    input  logic              c_valid,
    input  logic [TAG_W-1:0]  c_tag_out,
    input  logic [DATA_W-1:0] c_dout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [STAT_W-1:0] hit_cnt,
    output logic [STAT_W-1:0] miss_cnt
);

    localparam int IDX_W = ADDR_W - 5;

    typedef enum logic [2:0] {IDLE, CMP, WB, ALLOC, FILL, DONE} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     we_q, we_d;
    logic                     retry_q, retry_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
    logic [3:0][DATA_W-1:0]   fbuf_q, fbuf_d;
    logic [STAT_W-1:0]        hit_q, hit_d;
    logic [STAT_W-1:0]        miss_q, miss_d;

    logic [IDX_W-1:0]         idx;
    logic [TAG_W-1:0]         tag;
    logic                     unused_tag_hi;

    assign idx = addr_q[ADDR_W-4:2];
    assign tag = {{(TAG_W-3){1'b0}}, addr_q[ADDR_W-1 -: 3]};
    assign unused_tag_hi = ^c_tag_out[TAG_W-1:3];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            retry_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fbuf_q  <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            retry_q <= retry_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fbuf_q  <= fbuf_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        retry_d = retry_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fbuf_d  = fbuf_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (c_hit && c_valid) begin
                    if (!we_q) rdata_d = c_dout;
                    if (!retry_q && hit_q != '1) hit_d = hit_q + 1'b1;
                    state_d = DONE;
                end else begin
                    if (miss_q != '1) miss_d = miss_q + 1'b1;
                    retry_d = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = (c_valid && c_dirty) ? WB : ALLOC;
                end
            end
            WB: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ALLOC;
                end
            end
            ALLOC: begin
                if (mem_ack) begin
                    fbuf_d[cnt_q] = mem_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = FILL;
                end
            end
            FILL: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = CMP;
            end
            DONE: begin
                retry_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        c_en       = 1'b0;
        c_comp     = 1'b0;
        c_write    = 1'b0;
        c_valid_in = 1'b0;
        c_addr     = '0;
        c_tag_in   = '0;
        c_din      = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            CMP: begin
                c_en     = 1'b1;
                c_comp   = 1'b1;
                c_write  = we_q;
                c_addr   = addr_q;
                c_tag_in = tag;
                c_din    = wdata_q;
            end
            WB: begin
                c_en      = 1'b1;
                c_addr    = {idx, cnt_q};
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {c_tag_out[2:0], idx, cnt_q};
                mem_wdata = c_dout;
            end
            ALLOC: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:2], cnt_q};
            end
            FILL: begin
                c_en       = 1'b1;
                c_write    = 1'b1;
                c_valid_in = 1'b1;
                c_tag_in   = tag;
                c_addr     = {idx, cnt_q};
                c_din      = fbuf_q[cnt_q];
            end
            default: ;
        endcase
    end

    assign cpu_ready = (state_q == IDLE);
    assign cpu_done  = (state_q == DONE);
    assign cpu_rdata = rdata_q;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Random load/store traffic against a cache/memory environment and a
// word-level reference of what the CPU should observe.
module tb_cache_miss_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [12:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready, cpu_done;
    logic [15:0] cpu_rdata;
    logic        c_en, c_comp, c_write, c_valid_in;
    logic [12:0] c_addr;
    logic [4:0]  c_tag_in;
    logic [15:0] c_din;
    logic        c_hit, c_dirty, c_valid;
    logic [4:0]  c_tag_out;
    logic [15:0] c_dout;
    logic        mem_req, mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] hit_cnt, miss_cnt;

    cache_miss_controller dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata),
        .c_en(c_en), .c_comp(c_comp), .c_write(c_write),
        .c_valid_in(c_valid_in), .c_addr(c_addr),
        .c_tag_in(c_tag_in), .c_din(c_din),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid),
        .c_tag_out(c_tag_out), .c_dout(c_dout),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [12:0] a);
        return 16'({3'b0, a} * 16'd7) ^ 16'hA5C3;
    endfunction

    // Cache arrays: combinational read, written at the clock edge.
    bit          cv [256];
    bit          cd [256];
    logic [4:0]  ct [256];
    logic [15:0] cdat [256][4];

    assign c_valid   = cv[c_addr[9:2]];
    assign c_dirty   = cd[c_addr[9:2]];
    assign c_tag_out = ct[c_addr[9:2]];
    assign c_dout    = cdat[c_addr[9:2]][c_addr[1:0]];
    assign c_hit     = c_en && c_comp && c_valid && (c_tag_out == c_tag_in);

    always @(posedge clk) begin
        if (c_en && c_write) begin
            if (c_comp) begin
                if (c_hit) begin
                    cdat[c_addr[9:2]][c_addr[1:0]] <= c_din;
                    cd[c_addr[9:2]] <= 1'b1;
                end
            end else begin
                cdat[c_addr[9:2]][c_addr[1:0]] <= c_din;
                cv[c_addr[9:2]] <= c_valid_in;
                ct[c_addr[9:2]] <= c_tag_in;
                cd[c_addr[9:2]] <= 1'b0;
            end
        end
    end

    // Memory: unwritten words read back their init pattern.
    bit          mw [8192];
    logic [15:0] mem_arr [8192];
    int          dly = 0;
    int          dly_lo = 0;
    int          dly_hi = 2;

    function automatic logic [15:0] mem_rd(input logic [12:0] a);
        return mw[a] ? mem_arr[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        mem_ack <= 1'b0;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                mem_arr[mem_addr] <= mem_wdata;
                mw[mem_addr] <= 1'b1;
            end
        end else if (mem_req) begin
            if (dly == 0) begin
                mem_ack   <= 1'b1;
                mem_rdata <= mem_rd(mem_addr);
                dly <= $urandom_range(dly_hi, dly_lo);
            end else begin
                dly <= dly - 1;
            end
        end
    end

    int wbeats = 0;
    int rbeats = 0;
    int reqcyc = 0;
    int ndone = 0;

    always @(posedge clk) begin
        if (mem_req) reqcyc++;
        if (mem_req && mem_ack) begin
            if (mem_we) wbeats++;
            else rbeats++;
        end
    end

    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic [29:0] p_vec = '0;

    always @(negedge clk) begin
        if (rst && mem_req && p_req && !p_ack)
            check("mem_stable", 32'({mem_addr, mem_we, mem_wdata}),
                  32'(p_vec));
        p_req <= rst && mem_req;
        p_ack <= mem_ack;
        p_vec <= {mem_addr, mem_we, mem_wdata};
        if (cpu_done) ndone++;
    end

    // Reference: what the CPU sees plus which line the cache holds.
    logic [15:0] gold [8192];
    bit          rv [256];
    bit          rd [256];
    logic [2:0]  rt [256];
    int          ref_hits = 0;
    int          ref_miss = 0;
    int          accepted = 0;

    task automatic do_req(input logic we, input logic [12:0] a,
                          input logic [15:0] wd);
        int lat, w0, r0, q0;
        bit got, hit, dv;
        logic [2:0] vt;
        logic [7:0] ix;
        ix = a[9:2];
        @(negedge clk);
        for (int k = 0; k < 50 && !cpu_ready; k++) @(negedge clk);
        check("ready", 32'(cpu_ready), 32'd1);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        w0 = wbeats;
        r0 = rbeats;
        q0 = reqcyc;
        @(posedge clk);
        accepted++;
        hit = rv[ix] && rt[ix] == a[12:10];
        dv = !hit && rv[ix] && rd[ix];
        vt = rt[ix];
        if (hit) begin
            ref_hits++;
        end else begin
            ref_miss++;
            rv[ix] = 1'b1;
            rt[ix] = a[12:10];
            rd[ix] = 1'b0;
        end
        if (we) begin
            gold[a] = wd;
            rd[ix] = 1'b1;
        end
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            lat++;
            cpu_req = 1'b0;
            if (cpu_done) begin
                got = 1'b1;
                break;
            end
            check("busy_ready", 32'(cpu_ready), 32'd0);
            if ($urandom_range(3, 0) == 0) begin
                cpu_req = 1'b1;
                cpu_we = 1'($urandom);
                cpu_addr = 13'($urandom);
                cpu_wdata = 16'($urandom);
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (!we) check("rdata", 32'(cpu_rdata), 32'(gold[a]));
        check("hit_cnt", 32'(hit_cnt), 32'(ref_hits));
        check("miss_cnt", 32'(miss_cnt), 32'(ref_miss));
        check("wb_beats", 32'(wbeats - w0), dv ? 32'd4 : 32'd0);
        check("rd_beats", 32'(rbeats - r0), hit ? 32'd0 : 32'd4);
        if (hit) begin
            check("hit_lat", 32'(lat), 32'd2);
            check("hit_noreq", 32'(reqcyc - q0), 32'd0);
        end else begin
            check("miss_lat", 32'(lat >= 11), 32'd1);
        end
        if (dv)
            for (int w = 0; w < 4; w++)
                check("wb_data", 32'(mem_rd({vt, ix, 2'(w)})),
                      32'(gold[{vt, ix, 2'(w)}]));
    endtask

    initial begin
        int r0;
        bit hit2;
        logic [12:0] a;
        rst = 1'b0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 8192; i++) gold[i] = init_val(13'(i));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 32'd1);
        check("rst_done", 32'(cpu_done), 32'd0);
        check("rst_memreq", 32'(mem_req), 32'd0);
        check("rst_cen", 32'(c_en), 32'd0);
        check("rst_hits", 32'(hit_cnt), 32'd0);
        check("rst_miss", 32'(miss_cnt), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'd0);
        rst = 1'b1;

        do_req(1'b0, 13'h0004, 16'h0);
        do_req(1'b0, 13'h0005, 16'h0);
        do_req(1'b1, 13'h0006, 16'hBEEF);
        dly_lo = 3;
        dly_hi = 3;
        do_req(1'b0, 13'h0406, 16'h0);
        check("wb_beef", 32'(mem_rd(13'h0006)), 32'hBEEF);
        do_req(1'b0, 13'h0006, 16'h0);
        dly_lo = 0;
        dly_hi = 2;

        for (int t = 0; t < 200; t++) begin
            a = {3'($urandom), 6'd0, 2'($urandom), 2'($urandom)};
            do_req(1'($urandom), a, 16'($urandom));
        end

        // Abort a refill of line 200 in the middle of beat 2.
        @(negedge clk);
        for (int k = 0; k < 50 && !cpu_ready; k++) @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = {3'd5, 8'd200, 2'd1};
        r0 = rbeats;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        for (int k = 0; k < 100 && rbeats - r0 < 2; k++) @(negedge clk);
        check("abort_beats", 32'(rbeats - r0), 32'd2);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", 32'(cpu_ready), 32'd1);
        check("abort_memreq", 32'(mem_req), 32'd0);
        check("abort_hits", 32'(hit_cnt), 32'd0);
        check("abort_miss", 32'(miss_cnt), 32'd0);
        check("abort_rdata", 32'(cpu_rdata), 32'd0);
        check("abort_done", 32'(cpu_done), 32'd0);
        rst = 1'b1;
        ref_hits = 0;
        ref_miss = 0;
        hit2 = cv[200];
        check("abort_line", 32'(hit2), 32'd0);

        do_req(1'b0, {3'd5, 8'd200, 2'd1}, 16'h0);
        do_req(1'b1, {3'd5, 8'd200, 2'd3}, 16'h1234);
        do_req(1'b0, {3'd6, 8'd200, 2'd3}, 16'h0);
        do_req(1'b0, {3'd5, 8'd200, 2'd3}, 16'h0);

        repeat (3) @(negedge clk);
        check("done_count", 32'(ndone), 32'(accepted));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
